// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI register responder.
// Command byte field positions and the read-fill value live here.
package spi_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_t;

    localparam int CMD_ADDR_MSB = 7;
    localparam int CMD_ADDR_LSB = 3;
    localparam int CMD_WR_BIT   = 1;

    localparam logic [7:0] READ_FILL = 8'h00;

endpackage

// File: rtl/spi_resp_sync.sv
// SCLK/SS_n/MOSI synchronizer with registered edge detection.
// Edge pulses and mosi_s share one pipeline depth so they stay aligned.
module spi_resp_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk_in,
    input  logic ss_n_in,
    input  logic mosi_in,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_fall,
    output logic ss_rise,
    output logic ss_act,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_ss_prev;
    logic                   w_sclk;
    logic                   w_ss;

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss   = r_ss_sync[SYNC_STAGES-1];

    // SS_n resets low so a select already held at release is not seen as a fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_ss_prev   <= 1'b0;
            sclk_rise   <= 1'b0;
            sclk_fall   <= 1'b0;
            ss_fall     <= 1'b0;
            ss_rise     <= 1'b0;
            ss_act      <= 1'b0;
            mosi_s      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n_in};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
            r_sclk_prev <= w_sclk;
            r_ss_prev   <= w_ss;
            sclk_rise   <= w_sclk & ~r_sclk_prev;
            sclk_fall   <= ~w_sclk & r_sclk_prev;
            ss_fall     <= ~w_ss & r_ss_prev;
            ss_rise     <= w_ss & ~r_ss_prev;
            ss_act      <= ~w_ss;
            mosi_s      <= r_mosi_sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder with MAX3421E-style command byte over a
// register file that the fabric host port can also read and write.
module spi_reg_responder
    import spi_resp_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 5
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              spi_sclk,
    input  logic              spi_ss_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic [7:0]        status_in,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              spi_wr_pulse,
    output logic [ADDR_W-1:0] spi_wr_addr,
    output logic [7:0]        spi_wr_data,
    output logic              busy
);

    localparam int NREGS = 1 << ADDR_W;

    logic [7:0]        r_regs [NREGS];
    state_t            r_state;
    logic [2:0]        r_bitcnt;
    logic [6:0]        r_rx;
    logic [7:0]        r_tx;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr;
    logic              r_byte_done;
    logic [7:0]        r_host_rdata;
    logic              r_wr_pulse;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;

    logic              w_sclk_rise;
    logic              w_sclk_fall;
    logic              w_ss_fall;
    logic              w_ss_rise;
    logic              w_ss_act;
    logic              w_mosi_s;
    logic [7:0]        w_rx_byte;
    logic              w_last_bit;
    logic              w_bit_rise;
    logic              w_bit_fall;
    logic              w_commit;

    spi_resp_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .sclk_in  (spi_sclk),
        .ss_n_in  (spi_ss_n),
        .mosi_in  (spi_mosi),
        .sclk_rise(w_sclk_rise),
        .sclk_fall(w_sclk_fall),
        .ss_fall  (w_ss_fall),
        .ss_rise  (w_ss_rise),
        .ss_act   (w_ss_act),
        .mosi_s   (w_mosi_s)
    );

    assign w_rx_byte  = {r_rx, w_mosi_s};
    assign w_last_bit = (r_bitcnt == 3'd7);
    assign w_bit_rise = w_sclk_rise & w_ss_act & ~w_ss_rise;
    assign w_bit_fall = w_sclk_fall & w_ss_act & ~w_ss_rise;
    assign w_commit   = (r_state == DATA) & r_wr & w_bit_rise & w_last_bit;

    assign spi_miso     = r_tx[7];
    assign busy         = (r_state != IDLE);
    assign host_rdata   = r_host_rdata;
    assign spi_wr_pulse = r_wr_pulse;
    assign spi_wr_addr  = r_wr_addr;
    assign spi_wr_data  = r_wr_data;

    // Transaction FSM: bit counting, MOSI/MISO shifting, address walk
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state     <= IDLE;
            r_bitcnt    <= 3'd0;
            r_rx        <= 7'd0;
            r_tx        <= 8'h00;
            r_addr      <= '0;
            r_wr        <= 1'b0;
            r_byte_done <= 1'b0;
            r_wr_pulse  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
        end else begin
            r_wr_pulse <= 1'b0;
            if (w_ss_rise) begin
                r_state     <= IDLE;
                r_bitcnt    <= 3'd0;
                r_tx        <= 8'h00;
                r_byte_done <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (w_ss_fall) begin
                            r_state     <= CMD;
                            r_bitcnt    <= 3'd0;
                            r_tx        <= status_in;
                            r_byte_done <= 1'b0;
                        end
                    end
                    CMD, DATA: begin
                        if (w_bit_rise) begin
                            r_rx     <= w_rx_byte[6:0];
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (w_last_bit) begin
                                r_byte_done <= 1'b1;
                                if (r_state == CMD) begin
                                    r_state <= DATA;
                                    r_addr  <= ADDR_W'(w_rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB]);
                                    r_wr    <= w_rx_byte[CMD_WR_BIT];
                                end else if (r_wr) begin
                                    r_wr_pulse <= 1'b1;
                                    r_wr_addr  <= r_addr;
                                    r_wr_data  <= w_rx_byte;
                                    r_addr     <= r_addr + ADDR_W'(1);
                                end
                            end
                        end else if (w_bit_fall) begin
                            if (r_byte_done) begin
                                r_byte_done <= 1'b0;
                                if (r_wr) begin
                                    r_tx <= READ_FILL;
                                end else begin
                                    r_tx   <= r_regs[r_addr];
                                    r_addr <= r_addr + ADDR_W'(1);
                                end
                            end else begin
                                r_tx <= {r_tx[6:0], 1'b0};
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Register file: SPI commit is applied last so it wins a same-address clash
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 8'h00;
            end
            r_host_rdata <= 8'h00;
        end else begin
            r_host_rdata <= r_regs[host_addr];
            if (host_we) begin
                r_regs[host_addr] <= host_wdata;
            end
            if (w_commit) begin
                r_regs[r_addr] <= w_rx_byte;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Scoreboard bench for spi_reg_responder: MISO bytes and write
// commits are queued as stimulus is driven and popped on arrival.
module tb_spi_reg_responder;

    localparam int AW   = 5;
    localparam int HALF = 80;

    logic          clk_clk = 1'b0;
    logic          reset_reset_n = 1'b0;
    logic          spi_sclk = 1'b0;
    logic          spi_ss_n = 1'b1;
    logic          spi_mosi = 1'b0;
    logic          spi_miso;
    logic [7:0]    status_in = 8'h00;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [7:0]    host_wdata = 8'h00;
    logic [7:0]    host_rdata;
    logic          spi_wr_pulse;
    logic [AW-1:0] spi_wr_addr;
    logic [7:0]    spi_wr_data;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int n_pulse = 0;
    int n_exp   = 0;

    logic [7:0]  mdl [32];
    logic [7:0]  q_miso [$];
    logic [12:0] q_wr [$];

    spi_reg_responder #(
        .SYNC_STAGES(2),
        .ADDR_W     (AW)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .spi_sclk     (spi_sclk),
        .spi_ss_n     (spi_ss_n),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .status_in    (status_in),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_rdata   (host_rdata),
        .spi_wr_pulse (spi_wr_pulse),
        .spi_wr_addr  (spi_wr_addr),
        .spi_wr_data  (spi_wr_data),
        .busy         (busy)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // write-commit monitor
    always @(negedge clk_clk) begin
        if (reset_reset_n && spi_wr_pulse) begin
            logic [12:0] e;
            n_pulse++;
            check("wr_expected", 32'(q_wr.size() > 0), 1);
            if (q_wr.size() > 0) begin
                e = q_wr.pop_front();
                check("wr_addr", 32'(spi_wr_addr), 32'(e[12:8]));
                check("wr_data", 32'(spi_wr_data), 32'(e[7:0]));
            end
        end
    end

    task automatic exp_wr(input logic [4:0] a, input logic [7:0] d);
        q_wr.push_back({a, d});
        mdl[a] = d;
        n_exp++;
    endtask

    task automatic ss_low();
        @(negedge clk_clk);
        #2 spi_ss_n = 1'b0;
        #(HALF);
    endtask

    task automatic ss_high();
        spi_ss_n = 1'b1;
        repeat (10) @(negedge clk_clk);
    endtask

    task automatic spi_byte(input logic [7:0] mo, input logic [7:0] mi);
        logic [7:0] got;
        logic [7:0] e;
        got = 8'h00;
        q_miso.push_back(mi);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = mo[i];
            #(HALF) spi_sclk = 1'b1;
            got = {got[6:0], spi_miso};
            #(HALF) spi_sclk = 1'b0;
        end
        e = q_miso.pop_front();
        check("miso", 32'(got), 32'(e));
    endtask

    task automatic spi_bits(input logic [7:0] mo, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = mo[i];
            #(HALF) spi_sclk = 1'b1;
            #(HALF) spi_sclk = 1'b0;
        end
    endtask

    task automatic host_wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk_clk);
        host_we = 1'b1;
        host_addr = a;
        host_wdata = d;
        @(negedge clk_clk);
        host_we = 1'b0;
        mdl[a] = d;
    endtask

    task automatic host_rd(input logic [4:0] a);
        @(negedge clk_clk);
        host_addr = a;
        @(negedge clk_clk);
        check($sformatf("host_rd%0d", a), 32'(host_rdata), 32'(mdl[a]));
    endtask

    // host write timed onto the commit edge of the n-th following SCLK rise
    task automatic host_hit(input int n, input logic [4:0] a,
                            input logic [7:0] d);
        repeat (n) @(posedge spi_sclk);
        #26;
        host_we = 1'b1;
        host_addr = a;
        host_wdata = d;
        #10 host_we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 8'h00;

        #23;
        check("rst_miso", 32'(spi_miso), 0);
        check("rst_rdata", 32'(host_rdata), 0);
        check("rst_pulse", 32'(spi_wr_pulse), 0);
        check("rst_wraddr", 32'(spi_wr_addr), 0);
        check("rst_wrdata", 32'(spi_wr_data), 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        repeat (5) @(negedge clk_clk);
        host_rd(0);
        host_rd(10);
        host_rd(31);

        // SPI write burst
        status_in = 8'h5A;
        ss_low();
        check("busy_on", 32'(busy), 1);
        spi_byte(8'h52, 8'h5A);
        exp_wr(10, 8'hA5);
        spi_byte(8'hA5, 8'h00);
        exp_wr(11, 8'h3C);
        spi_byte(8'h3C, 8'h00);
        ss_high();
        check("busy_off", 32'(busy), 0);
        host_rd(10);
        host_rd(11);

        // SPI read with address wrap
        host_wr(31, 8'h11);
        host_wr(0, 8'h22);
        status_in = 8'hC3;
        ss_low();
        spi_byte(8'hF8, 8'hC3);
        spi_byte(8'h00, mdl[31]);
        spi_byte(8'h00, mdl[0]);
        ss_high();

        // abort partway through a write data byte
        status_in = 8'h81;
        ss_low();
        spi_byte(8'h0A, 8'h81);
        spi_bits(8'hFF, 5);
        spi_ss_n = 1'b1;
        #26 check("abort_busy3", 32'(busy), 1);
        #10 check("abort_busy4", 32'(busy), 0);
        repeat (10) @(negedge clk_clk);
        host_rd(1);
        ss_low();
        spi_byte(8'h12, 8'h81);
        exp_wr(2, 8'h5C);
        spi_byte(8'h5C, 8'h00);
        ss_high();
        ss_low();
        spi_byte(8'h08, 8'h81);
        spi_byte(8'h00, mdl[1]);
        spi_byte(8'h00, mdl[2]);
        ss_high();

        // same-address and different-address host/SPI collisions
        status_in = 8'h44;
        ss_low();
        spi_byte(8'h22, 8'h44);
        exp_wr(4, 8'h99);
        exp_wr(5, 8'h66);
        fork
            begin
                spi_byte(8'h99, 8'h00);
                spi_byte(8'h66, 8'h00);
            end
            begin
                host_hit(8, 4, 8'h77);
                host_hit(8, 7, 8'h44);
            end
        join
        mdl[7] = 8'h44;
        ss_high();
        host_rd(4);
        host_rd(5);
        host_rd(7);

        // reset in the middle of a read burst
        status_in = 8'h3C;
        ss_low();
        spi_byte(8'h50, 8'h3C);
        spi_byte(8'h00, mdl[10]);
        spi_bits(8'h00, 3);
        #20 reset_reset_n = 1'b0;
        #1;
        check("mid_rst_miso", 32'(spi_miso), 0);
        check("mid_rst_busy", 32'(busy), 0);
        for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
        repeat (3) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        repeat (12) @(negedge clk_clk);
        check("rel_ss_low", 32'(busy), 0);
        #2 spi_bits(8'hFF, 8);
        check("rel_sclk", 32'(busy), 0);
        ss_high();
        host_rd(10);
        status_in = 8'hE7;
        ss_low();
        spi_byte(8'h52, 8'hE7);
        exp_wr(10, 8'h12);
        spi_byte(8'h12, 8'h00);
        ss_high();
        ss_low();
        spi_byte(8'h50, 8'hE7);
        spi_byte(8'h00, mdl[10]);
        ss_high();
        host_rd(10);

        repeat (10) @(negedge clk_clk);
        check("wr_left", 32'(q_wr.size()), 0);
        check("pulses", 32'(n_pulse), 32'(n_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
